// File: rtl/minrv32_mem_model.sv
// minrv32_mem_model: stateful memory responder for the minrv32 native memory
// interface. Holds a word-addressed backing store, inserts fixed, LFSR-random
// or fetch-only wait states, and raises sticky protocol and range flags.
//
// Handshake: the core raises mem_valid with a stable request (addr, wdata,
// wstrb, instr) and holds it until it observes mem_ready=1. mem_ready is a
// one-cycle registered pulse; the rising edge at the end of that cycle is the
// handshake edge, where the write (if any) commits and txn_count increments.
// The request must stay unchanged from the sampling edge through the
// handshake edge, otherwise protocol_err is raised.
//
// dbg_state exposes the FSM: 0 = IDLE, 1 = WAIT, 2 = RESP.
module minrv32_mem_model #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_MODE   = 0,
  parameter int unsigned FIXED_WAIT  = 0,
  parameter logic [7:0]  WAIT_MASK   = 8'd3,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        mem_valid,
  input  logic        mem_instr,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_wstrb,
  output logic        mem_ready,
  output logic [31:0] mem_rdata,
  output logic        protocol_err,
  output logic        range_err,
  output logic [15:0] txn_count,
  output logic [1:0]  dbg_state
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN_BYTES = 33'(DEPTH_WORDS) << 2;
  localparam logic [7:0]  FIXED_W8   = 8'(FIXED_WAIT);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t        state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   addr_q;
  logic [31:0]   wdata_q;
  logic [3:0]    wstrb_q;
  logic [AW-1:0] idx_q;
  logic          oor_q;
  logic [7:0]    wcnt;
  logic [15:0]   lfsr;

  logic [31:0]   req_addr;
  logic [31:0]   req_off;
  logic          req_ok;
  logic [AW-1:0] req_idx;
  logic [31:0]   rd_word;
  logic [7:0]    wait_load;
  logic          violation;

  assign dbg_state = state;

  // The instr flag only matters when the wait count is chosen at sampling
  // time, so it is not kept past the IDLE edge.
  always_comb begin
    wait_load = 8'd0;
    case (WAIT_MODE)
      1:       wait_load = lfsr[7:0] & WAIT_MASK;
      2:       wait_load = mem_instr ? FIXED_W8 : 8'd0;
      default: wait_load = FIXED_W8;
    endcase
  end

  // Address decode: live request in IDLE (zero-wait path), latched one later.
  always_comb begin
    req_addr = (state == ST_IDLE) ? mem_addr : addr_q;
    req_off  = req_addr - BASE_ADDR;
    req_ok   = ({1'b0, req_off} < SPAN_BYTES) && (req_addr[1:0] == 2'b00);
    req_idx  = req_off[AW+1:2];
    rd_word  = req_ok ? mem[req_idx] : 32'h0;
  end

  // Request stability check while a transaction is outstanding.
  always_comb begin
    violation = !mem_valid
             || (mem_addr != addr_q)
             || (mem_wstrb != wstrb_q)
             || ((wstrb_q != 4'h0) && (mem_wdata != wdata_q));
  end

  // Free-running Fibonacci LFSR, taps 16, 14, 13, 11.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lfsr <= LFSR_SEED;
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
    end
  end

  // Transaction FSM: IDLE -> (WAIT) -> RESP -> IDLE, with registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= ST_IDLE;
      mem_ready    <= 1'b0;
      mem_rdata    <= 32'h0;
      protocol_err <= 1'b0;
      range_err    <= 1'b0;
      txn_count    <= 16'h0;
      wcnt         <= 8'd0;
      addr_q       <= 32'h0;
      wdata_q      <= 32'h0;
      wstrb_q      <= 4'h0;
      idx_q        <= '0;
      oor_q        <= 1'b0;
    end else begin
      mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (mem_valid) begin
            addr_q  <= mem_addr;
            wdata_q <= mem_wdata;
            wstrb_q <= mem_wstrb;
            idx_q   <= req_idx;
            oor_q   <= !req_ok;
            wcnt    <= wait_load;
            if (!req_ok) range_err <= 1'b1;
            if (wait_load == 8'd0) begin
              state     <= ST_RESP;
              mem_ready <= 1'b1;
              mem_rdata <= rd_word;
            end else begin
              state <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          if (violation) protocol_err <= 1'b1;
          wcnt <= wcnt - 8'd1;
          if (wcnt == 8'd1) begin
            state     <= ST_RESP;
            mem_ready <= 1'b1;
            mem_rdata <= rd_word;
          end
        end
        ST_RESP: begin
          if (violation) protocol_err <= 1'b1;
          txn_count <= txn_count + 16'd1;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Byte-merged write commit on the handshake edge; dropped when out of range.
  always_ff @(posedge clk) begin
    if (resetn && (state == ST_RESP) && !oor_q) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb_q[i]) mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_minrv32_mem_model.sv
// Bench for minrv32_mem_model: three instances (fixed wait 0, fetch-only
// wait 3 at a high base, LFSR random wait with mask 7). A driver issues one
// transaction at a time and pushes the expected response; a monitor on the
// falling edge pops and compares whenever a mem_ready pulse appears.
module tb_minrv32_mem_model;

  localparam int ND = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [ND-1:0] rstn, valid, instr, ready, perr, rerr;
  logic [31:0]   addr  [ND];
  logic [31:0]   wdata [ND];
  logic [31:0]   rdata [ND];
  logic [3:0]    wstrb [ND];
  logic [15:0]   cnt   [ND];
  logic [1:0]    st    [ND];

  minrv32_mem_model #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000),
                      .WAIT_MODE(0), .FIXED_WAIT(0)) u_m0 (
    .clk(clk), .resetn(rstn[0]), .mem_valid(valid[0]), .mem_instr(instr[0]),
    .mem_addr(addr[0]), .mem_wdata(wdata[0]), .mem_wstrb(wstrb[0]),
    .mem_ready(ready[0]), .mem_rdata(rdata[0]), .protocol_err(perr[0]),
    .range_err(rerr[0]), .txn_count(cnt[0]), .dbg_state(st[0]));

  minrv32_mem_model #(.DEPTH_WORDS(256), .BASE_ADDR(32'h8000_0000),
                      .WAIT_MODE(2), .FIXED_WAIT(3)) u_m1 (
    .clk(clk), .resetn(rstn[1]), .mem_valid(valid[1]), .mem_instr(instr[1]),
    .mem_addr(addr[1]), .mem_wdata(wdata[1]), .mem_wstrb(wstrb[1]),
    .mem_ready(ready[1]), .mem_rdata(rdata[1]), .protocol_err(perr[1]),
    .range_err(rerr[1]), .txn_count(cnt[1]), .dbg_state(st[1]));

  minrv32_mem_model #(.DEPTH_WORDS(1024), .BASE_ADDR(32'h0000_0000),
                      .WAIT_MODE(1), .WAIT_MASK(8'd7)) u_m2 (
    .clk(clk), .resetn(rstn[2]), .mem_valid(valid[2]), .mem_instr(instr[2]),
    .mem_addr(addr[2]), .mem_wdata(wdata[2]), .mem_wstrb(wstrb[2]),
    .mem_ready(ready[2]), .mem_rdata(rdata[2]), .protocol_err(perr[2]),
    .range_err(rerr[2]), .txn_count(cnt[2]), .dbg_state(st[2]));

  // ---------------- bookkeeping ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Scoreboard: expected read data plus latency window and issue cycle.
  logic [31:0] exp_q [$];
  bit          chk_q [$];
  int          lo_q  [$];
  int          hi_q  [$];
  int          iss_q [$];
  int          dut_q [$];

  logic [ND-1:0] mon_en;
  logic [ND-1:0] prev_rdy;
  logic [8:0]    lat_seen;

  // Reference model: word store keyed by instance and word offset.
  logic [31:0] model_mem [int];
  int          n_done   [ND];
  bit          exp_rerr [ND];
  bit          exp_perr [ND];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [31:0] base_of(input int d);
    return (d == 1) ? 32'h8000_0000 : 32'h0000_0000;
  endfunction

  function automatic longint span_of(input int d);
    return (d == 1) ? 64'd1024 : 64'd4096;
  endfunction

  function automatic bit model_ok(input int d, input logic [31:0] a);
    longint off;
    off = longint'(a) - longint'(base_of(d));
    return (off >= 0) && (off < span_of(d)) && (a % 4 == 0);
  endfunction

  function automatic int mkey(input int d, input logic [31:0] a);
    return d * 1048576 + int'((a - base_of(d)) / 4);
  endfunction

  // Latency (cycles from issue to mem_ready) each instance is allowed.
  task automatic lat_window(input int d, input logic ins, output int lo, output int hi);
    case (d)
      0:       begin lo = 1; hi = 1; end
      1:       begin lo = ins ? 4 : 1; hi = lo; end
      default: begin lo = 1; hi = 8; end
    endcase
  endtask

  task automatic chk_status(input int d, input string tag);
    check32($sformatf("%s_txn_count_d%0d", tag, d), {16'h0, cnt[d]}, 32'(n_done[d] % 65536));
    check32($sformatf("%s_range_err_d%0d", tag, d), {31'h0, rerr[d]}, {31'h0, exp_rerr[d]});
    check32($sformatf("%s_protocol_err_d%0d", tag, d), {31'h0, perr[d]}, {31'h0, exp_perr[d]});
  endtask

  // Wait (bounded) for mem_ready on instance d, then step past the handshake edge.
  task automatic wait_ready(input int d, output bit got);
    got = 1'b0;
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      if (ready[d]) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL ready_timeout_d%0d: no mem_ready within 64 cycles", d);
      if (exp_q.size() > 0) begin
        void'(exp_q.pop_back()); void'(chk_q.pop_back()); void'(lo_q.pop_back());
        void'(hi_q.pop_back());  void'(iss_q.pop_back()); void'(dut_q.pop_back());
      end
    end
    @(posedge clk);
    #1;
  endtask

  // One complete transaction; glitch toggles mem_addr for one WAIT cycle.
  task automatic txn(input int d, input logic ins, input logic [31:0] a,
                     input logic [31:0] wd, input logic [3:0] ws,
                     input int gap, input bit glitch);
    logic [31:0] e_data;
    logic [31:0] nw;
    bit          known, ok, got;
    int          key, lo, hi;
    ok  = model_ok(d, a);
    key = ok ? mkey(d, a) : 0;
    if (!ok) begin
      e_data = 32'h0; known = 1'b1; exp_rerr[d] = 1'b1;
    end else if (model_mem.exists(key)) begin
      e_data = model_mem[key]; known = 1'b1;
    end else begin
      e_data = 32'h0; known = 1'b0;
    end
    lat_window(d, ins, lo, hi);
    exp_q.push_back(e_data); chk_q.push_back(known); lo_q.push_back(lo);
    hi_q.push_back(hi); iss_q.push_back(cyc); dut_q.push_back(d);
    if (ok && ws != 4'h0 && (known || ws == 4'hF)) begin
      nw = e_data;
      for (int i = 0; i < 4; i++) if (ws[i]) nw[8*i +: 8] = wd[8*i +: 8];
      model_mem[key] = nw;
    end
    valid[d] = 1'b1; instr[d] = ins; addr[d] = a; wdata[d] = wd; wstrb[d] = ws;
    if (glitch) begin
      exp_perr[d] = 1'b1;
      @(posedge clk); #1;
      addr[d] = a ^ 32'h4;
      @(posedge clk); #1;
      addr[d] = a;
    end
    wait_ready(d, got);
    if (got) n_done[d]++;
    valid[d] = 1'b0;
    repeat (gap) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: pop and compare on every mem_ready pulse.
  always @(negedge clk) begin
    for (int d = 0; d < ND; d++) begin
      if (mon_en[d] && ready[d]) begin
        check32($sformatf("ready_not_back_to_back_d%0d", d), {31'h0, prev_rdy[d]}, 32'h0);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_ready_d%0d: got pulse, required none", d);
        end else begin
          logic [31:0] e;
          bit c;
          int lo, hi, iss, dd, lat;
          e = exp_q.pop_front(); c = chk_q.pop_front(); lo = lo_q.pop_front();
          hi = hi_q.pop_front(); iss = iss_q.pop_front(); dd = dut_q.pop_front();
          check32($sformatf("resp_instance_d%0d", d), 32'(d), 32'(dd));
          if (c) check32($sformatf("rdata_d%0d", d), rdata[d], e);
          lat = cyc - iss;
          n_cmp++;
          if (lat < lo || lat > hi) begin
            n_bad++;
            $display("FAIL latency_d%0d: got %0d required %0d..%0d", d, lat, lo, hi);
          end
          if (d == 2 && lat >= 1 && lat <= 8) lat_seen[lat] <= 1'b1;
        end
      end
      prev_rdy[d] <= ready[d];
    end
  end

  // Global watchdog.
  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [31:0] b1;
    bit got;
    b1 = 32'h8000_0000;
    rstn = '0; valid = '0; instr = '0; mon_en = '1; prev_rdy = '0; lat_seen = '0;
    for (int d = 0; d < ND; d++) begin
      addr[d] = 32'h0; wdata[d] = 32'h0; wstrb[d] = 4'h0;
      n_done[d] = 0; exp_rerr[d] = 1'b0; exp_perr[d] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      check32($sformatf("reset_ready_d%0d", d), {31'h0, ready[d]}, 32'h0);
      check32($sformatf("reset_rdata_d%0d", d), rdata[d], 32'h0);
      check32($sformatf("reset_state_d%0d", d), {30'h0, st[d]}, 32'h0);
      chk_status(d, "reset");
    end
    rstn = '1;
    @(posedge clk); #1;

    // ---- instance 0: zero wait ----
    txn(0, 1'b0, 32'h10, 32'h1234_5678, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    chk_status(0, "first_pair");
    txn(0, 1'b0, 32'h20, 32'hAABB_CCDD, 4'hF, 0, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h1122_3344, 4'b0101, 1, 1'b0);
    txn(0, 1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    for (int w = 0; w < 16; w++) txn(0, 1'b0, 32'h100 + 32'(4 * w), $urandom, 4'hF, 0, 1'b0);
    for (int n = 0; n < 120; n++) begin
      txn(0, 1'b0, 32'h100 + 32'(4 * $urandom_range(0, 15)), $urandom,
          4'($urandom_range(0, 15)), $urandom_range(0, 2), 1'b0);
    end
    chk_status(0, "random0");

    // Reset while the write response is on the bus: no commit, no count.
    mon_en[0] = 1'b0;
    valid[0] = 1'b1; instr[0] = 1'b0; addr[0] = 32'h100; wdata[0] = 32'hCAFE_F00D; wstrb[0] = 4'hF;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(negedge clk);
      got = ready[0];
    end
    check32("abort_resp_seen_d0", {31'h0, got}, 32'h1);
    #1 rstn[0] = 1'b0;
    #1;
    check32("abort_ready_async_d0", {31'h0, ready[0]}, 32'h0);
    valid[0] = 1'b0;
    #1 rstn[0] = 1'b1;
    n_done[0] = 0;
    @(posedge clk); #1;
    mon_en[0] = 1'b1;
    chk_status(0, "after_abort");
    txn(0, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1'b0);

    // ---- instance 1: fetch-only waits, high base ----
    txn(1, 1'b0, b1 + 32'h8, 32'h5EED_0008, 4'hF, 0, 1'b0);
    txn(1, 1'b1, b1 + 32'h8, 32'h0, 4'h0, 0, 1'b0);
    txn(1, 1'b0, b1 + 32'h8, 32'h0, 4'h0, 0, 1'b0);
    txn(1, 1'b0, b1, 32'h0BAD_F00D, 4'hF, 0, 1'b0);
    chk_status(1, "mode2");
    txn(1, 1'b0, b1 + 32'd1024, 32'h0, 4'h0, 0, 1'b0);
    txn(1, 1'b0, b1 + 32'h2, 32'h0, 4'h0, 0, 1'b0);
    txn(1, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    txn(1, 1'b0, b1 + 32'd1024, 32'hDEAD_BEEF, 4'hF, 0, 1'b0);
    txn(1, 1'b0, b1, 32'h0, 4'h0, 0, 1'b0);
    chk_status(1, "range");
    txn(1, 1'b1, b1 + 32'h8, 32'h0, 4'h0, 0, 1'b1);
    chk_status(1, "protocol");
    rstn[1] = 1'b0;
    #2;
    n_done[1] = 0; exp_rerr[1] = 1'b0; exp_perr[1] = 1'b0;
    chk_status(1, "err_clear");
    rstn[1] = 1'b1;
    @(posedge clk); #1;

    // Reset during WAIT of a write: the old word survives.
    txn(1, 1'b0, b1 + 32'h30, 32'h3030_3030, 4'hF, 0, 1'b0);
    mon_en[1] = 1'b0;
    valid[1] = 1'b1; instr[1] = 1'b1; addr[1] = b1 + 32'h30; wdata[1] = 32'hFFFF_0000; wstrb[1] = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rstn[1] = 1'b0;
    #1;
    check32("wait_abort_ready_d1", {31'h0, ready[1]}, 32'h0);
    check32("wait_abort_state_d1", {30'h0, st[1]}, 32'h0);
    valid[1] = 1'b0;
    #1 rstn[1] = 1'b1;
    n_done[1] = 0;
    @(posedge clk); #1;
    mon_en[1] = 1'b1;
    chk_status(1, "wait_abort");
    txn(1, 1'b0, b1 + 32'h30, 32'h0, 4'h0, 0, 1'b0);

    // ---- instance 2: random waits, back-to-back reads ----
    for (int w = 0; w < 8; w++) txn(2, 1'b0, 32'h200 + 32'(4 * w), $urandom, 4'hF, 0, 1'b0);
    for (int n = 0; n < 1000; n++) begin
      txn(2, 1'b0, 32'h200 + 32'(4 * $urandom_range(0, 7)), 32'h0, 4'h0, 0, 1'b0);
    end
    repeat (2) @(posedge clk);
    #1;
    for (int k = 1; k <= 8; k++) check32($sformatf("latency_seen_%0d", k), {31'h0, lat_seen[k]}, 32'h1);
    chk_status(2, "random2");

    repeat (4) @(posedge clk);
    #1;
    check32("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
